voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_scheduler_pkg.sv | 13 +
 rtl/voice_slot_buffer.sv | 48 ++++
 rtl/voice_scheduler.sv | 92 +++++++++
 tb/tb_voice_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_scheduler_pkg.sv
// Shared audio definitions: scheduler state encodings and default voice geometry.
package voice_scheduler_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int DIV_W_DEF      = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/voice_slot_buffer.sv
// One voice's divider storage: a pending buffer filled by a valid/ready handshake
// and an active register that only changes on frame-boundary commits.
module voice_slot_buffer
  import voice_scheduler_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  input  logic [DIV_W-1:0] upd_div,
  input  logic             commit,
  output logic             upd_ready,
  output logic [DIV_W-1:0] active_eff
);

  logic [DIV_W-1:0] pending;
  logic [DIV_W-1:0] active;
  logic             full;
  logic             full_nxt;
  logic             take;
  logic             drain;

  assign take     = upd_valid & upd_ready;
  assign drain    = commit & full;
  // A draining buffer is never ready, so take and drain are exclusive.
  assign full_nxt = drain ? 1'b0 : (full | take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      upd_ready <= 1'b1;
      active    <= '0;
    end else begin
      full      <= full_nxt;
      upd_ready <= ~full_nxt;
      if (drain) active <= pending;
    end
  end

  always_ff @(posedge clk) begin
    if (take) pending <= upd_div;
  end

  // Bypass lets the output mux see a committed value on the commit edge itself.
  assign active_eff = drain ? pending : active;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes NUM_VOICES divider registers onto one shared sample datapath,
// committing buffered updates only at frame boundaries to avoid tearing.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int DIV_W      = DIV_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [NUM_VOICES-1:0]         upd_valid,
  input  logic [NUM_VOICES*DIV_W-1:0]   upd_div,
  output logic [NUM_VOICES-1:0]         upd_ready,
  input  logic [NUM_VOICES-1:0]         mute,
  output logic [$clog2(NUM_VOICES)-1:0] slot,
  output logic [DIV_W-1:0]              divider,
  output logic                          frame_pulse,
  output logic [1:0]                    state
);

  localparam int SLOT_W = $clog2(NUM_VOICES);

  state_t            state_q;
  state_t            state_nxt;
  logic [SLOT_W-1:0] slot_nxt;
  logic              last_slot;
  logic              commit;
  logic [DIV_W-1:0]  active_eff [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_slot_buffer #(.DIV_W(DIV_W)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_valid  (upd_valid[v]),
      .upd_div    (upd_div[v*DIV_W +: DIV_W]),
      .commit     (commit),
      .upd_ready  (upd_ready[v]),
      .active_eff (active_eff[v])
    );
  end

  assign last_slot = (slot == SLOT_W'(NUM_VOICES - 1));

  always_comb begin
    state_nxt = state_q;
    slot_nxt  = slot;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Idle commits every edge so play always starts from the latest update.
        commit   = 1'b1;
        slot_nxt = '0;
        if (run) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        commit   = last_slot;
        slot_nxt = slot + SLOT_W'(1);
        if (!run) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        commit   = last_slot;
        slot_nxt = slot + SLOT_W'(1);
        if (run)            state_nxt = ST_PLAY;
        else if (last_slot) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        slot_nxt  = '0;
      end
    endcase
  end

  // Registered outputs: slot and divider are loaded together from next-slot values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot        <= '0;
      divider     <= '0;
      frame_pulse <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      slot        <= slot_nxt;
      frame_pulse <= (state_nxt == ST_PLAY) && (slot_nxt == '0);
      if ((state_nxt == ST_IDLE) || mute[slot_nxt]) divider <= '0;
      else                                          divider <= active_eff[slot_nxt];
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: per-cycle expectations are queued as
// stimulus is applied and compared once the DUT has taken the clock edge.
module tb_voice_scheduler;

  localparam int NV = 4;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic [NV-1:0]   upd_valid = '0;
  logic [NV*DW-1:0] upd_div = '0;
  logic [NV-1:0]   upd_ready;
  logic [NV-1:0]   mute = '0;
  logic [1:0]      slot;
  logic [DW-1:0]   divider;
  logic            frame_pulse;
  logic [1:0]      state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q [$];
  logic [16:0] e;
  logic [16:0] obs;

  voice_scheduler #(.NUM_VOICES(NV), .DIV_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .upd_valid   (upd_valid),
    .upd_div     (upd_div),
    .upd_ready   (upd_ready),
    .mute        (mute),
    .slot        (slot),
    .divider     (divider),
    .frame_pulse (frame_pulse),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] mk(input int st, input int sl, input int fp, input int dv);
    return {2'(st), 2'(sl), 1'(fp), 12'(dv)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int v, input int val);
    upd_div[v*DW +: DW] = 12'(val);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    obs = {state, slot, frame_pulse, divider};
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want %h", obs, 17'd0);
    end
    n_checks++;
    if (upd_ready !== 4'hf) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, want 1111", upd_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_sequence;
    for (int i = 0; i < 14; i++) begin
      run = (i >= 1 && i <= 8);
      if (i == 0)       exp_q.push_back(mk(0, 0, 0, 0));
      else if (i <= 8)  exp_q.push_back(mk(1, (i - 1) % 4, ((i - 1) % 4) == 0, 0));
      else if (i <= 12) exp_q.push_back(mk(2, i - 9, 0, 0));
      else              exp_q.push_back(mk(0, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL frame_seq i=%0d: got %h, want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_idle_update;
    n_checks++;
    if (upd_ready !== 4'hf) begin
      n_fail++;
      $display("FAIL idle_ready_pre: got %b, want 1111", upd_ready);
    end
    upd_valid = 4'b1101;
    set_div(0, 956);
    set_div(2, 956);
    set_div(3, 700);
    exp_q.push_back(mk(0, 0, 0, 0));
    tick();
    upd_valid = '0;
    e = exp_q.pop_front();
    obs = {state, slot, frame_pulse, divider};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL idle_out: got %h, want %h", obs, e);
    end
    n_checks++;
    if (upd_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL idle_ready_low: got %b, want 0010", upd_ready);
    end
    tick();
    n_checks++;
    if (upd_ready !== 4'hf) begin
      n_fail++;
      $display("FAIL idle_ready_back: got %b, want 1111", upd_ready);
    end
  endtask

  task automatic test_mid_frame_update;
    int exp_div [8] = '{956, 0, 956, 700, 1277, 0, 956, 700};
    for (int i = 0; i < 8; i++) begin
      run = 1'b1;
      if (i == 2) begin
        n_checks++;
        if (upd_ready[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL midframe_ready_pre: got %b, want 1", upd_ready[0]);
        end
        upd_valid[0] = 1'b1;
        set_div(0, 1277);
      end
      exp_q.push_back(mk(1, i % 4, (i % 4) == 0, exp_div[i]));
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midframe i=%0d: got %h, want %h", i, obs, e);
      end
      if (i == 2) begin
        upd_valid[0] = 1'b0;
        n_checks++;
        if (upd_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL midframe_ready_full: got %b, want 0", upd_ready[0]);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (upd_ready[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL midframe_ready_commit: got %b, want 1", upd_ready[0]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int exp_div [9] = '{1277, 0, 956, 700, 100, 0, 956, 700, 200};
    upd_valid[0] = 1'b1;
    set_div(0, 100);
    for (int j = 0; j < 9; j++) begin
      if (j == 5) begin
        n_checks++;
        if (upd_ready[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_ready_after_commit: got %b, want 1", upd_ready[0]);
        end
      end
      exp_q.push_back(mk(1, j % 4, (j % 4) == 0, exp_div[j]));
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL backpressure j=%0d: got %h, want %h", j, obs, e);
      end
      if (j == 0) begin
        set_div(0, 200);
        n_checks++;
        if (upd_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready_full: got %b, want 0", upd_ready[0]);
        end
      end
      if (j == 5) begin
        upd_valid[0] = 1'b0;
        n_checks++;
        if (upd_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_second_accept: got %b, want 0", upd_ready[0]);
        end
      end
    end
  endtask

  task automatic test_mute;
    int exp_div [11] = '{0, 956, 0, 200, 0, 956, 0, 200, 0, 956, 700};
    mute[3] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 7) mute[3] = 1'b0;
      exp_q.push_back(mk(1, (k + 1) % 4, ((k + 1) % 4) == 0, exp_div[k]));
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mute k=%0d: got %h, want %h", k, obs, e);
      end
    end
  endtask

  task automatic test_run_glitch;
    logic run_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [16:0] exp_seq [5];
    exp_seq = '{mk(2, 0, 0, 200), mk(1, 1, 0, 0), mk(2, 2, 0, 956),
                mk(1, 3, 0, 700), mk(1, 0, 1, 200)};
    for (int m = 0; m < 5; m++) begin
      run = run_seq[m];
      exp_q.push_back(exp_seq[m]);
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL run_glitch m=%0d: got %h, want %h", m, obs, e);
      end
    end
  endtask

  task automatic test_drain_stop;
    logic run_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [16:0] exp_seq [5];
    exp_seq = '{mk(1, 1, 0, 0), mk(2, 2, 0, 956), mk(2, 3, 0, 700),
                mk(0, 0, 0, 0), mk(0, 0, 0, 0)};
    for (int n = 0; n < 5; n++) begin
      run = run_seq[n];
      exp_q.push_back(exp_seq[n]);
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drain_stop n=%0d: got %h, want %h", n, obs, e);
      end
    end
  endtask

  task automatic test_reset_midplay;
    logic [16:0] exp_seq [3];
    exp_seq = '{mk(1, 0, 1, 200), mk(1, 1, 0, 0), mk(1, 2, 0, 956)};
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        upd_valid[1] = 1'b1;
        set_div(1, 333);
      end
      exp_q.push_back(exp_seq[i]);
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pre_reset i=%0d: got %h, want %h", i, obs, e);
      end
    end
    upd_valid = '0;
    n_checks++;
    if (upd_ready !== 4'b1101) begin
      n_fail++;
      $display("FAIL pre_reset_ready: got %b, want 1101", upd_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {state, slot, frame_pulse, divider};
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset_out: got %h, want %h", obs, 17'd0);
    end
    n_checks++;
    if (upd_ready !== 4'hf) begin
      n_fail++;
      $display("FAIL async_reset_ready: got %b, want 1111", upd_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1, i, i == 0, 0));
      tick();
      e = exp_q.pop_front();
      obs = {state, slot, frame_pulse, divider};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL post_reset i=%0d: got %h, want %h", i, obs, e);
      end
    end
    n_checks++;
    if (upd_ready !== 4'hf) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b, want 1111", upd_ready);
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_sequence();
    test_idle_update();
    test_mid_frame_update();
    test_backpressure();
    test_mute();
    test_run_glitch();
    test_drain_stop();
    test_reset_midplay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
